// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave port.
//   state_e        : frame FSM states
//   sample_rising  : true when the sample edge is SCLK rising for a CPOL/CPHA pair
//   DefaultDataWidth: default frame length in bits
package spi_pkg;

  localparam int unsigned DefaultDataWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StWaitDesel
  } state_e;

  // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling SCLK.
  function automatic logic sample_rising(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulse detection.
//   clk, rst_n : system clock, async active-low reset
//   sig_i      : asynchronous input pin
//   level_o    : synchronized level (last synchronizer stage)
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], sig_i};
    prev_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[Stages-1];
  assign rise_o  = sync_q[Stages-1] & ~prev_q;
  assign fall_o  = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave endpoint, oversampled on CLK, all four CPOL/CPHA modes, LSB first.
//   CLK, RST_N        : system clock, async active-low reset
//   CPOL, CPHA        : SPI mode, latched at frame start
//   SCLK, SS_N, MOSI  : SPI pins from the master (asynchronous)
//   MISO, MISO_OE     : serial data to master and its pad enable
//   TX_DATA, TX_LOAD  : transmit byte and load strobe (taken when TX_READY=1)
//   TX_READY          : holding buffer empty
//   RX_DATA, RX_VALID : last received frame and its one-cycle update pulse
//   BUSY              : frame in progress
//   FRAME_ERR         : one-cycle pulse when select drops mid-frame
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_TX     = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  SCLK,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_LOAD,
  output logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  BUSY,
  output logic                  FRAME_ERR
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk    (CLK),
    .rst_n  (RST_N),
    .sig_i  (SCLK),
    .level_o(sclk_level),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Resets to deselected so no spurious select edge is seen out of reset.
  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .clk    (CLK),
    .rst_n  (RST_N),
    .sig_i  (SS_N),
    .level_o(ss_level),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk    (CLK),
    .rst_n  (RST_N),
    .sig_i  (MOSI),
    .level_o(mosi_level),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  state_e                state_q, state_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  first_q, first_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  oe_q, oe_d;
  logic [SYNC_STAGES:0]  settle_q, settle_d;

  logic                  settled;
  logic                  sample_ev, change_ev;
  logic [DATA_WIDTH-1:0] rx_shifted;

  // The SS_N synchronizer only reflects the real pin once its pipeline has
  // refilled after reset; until then the FSM stays parked in StWaitDesel.
  assign settled = settle_q[SYNC_STAGES];

  always_comb begin
    sample_ev  = sample_rising(cpol_q, cpha_q) ? sclk_rise : sclk_fall;
    change_ev  = sample_rising(cpol_q, cpha_q) ? sclk_fall : sclk_rise;
    rx_shifted = {mosi_level, rx_sr_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    oe_d        = oe_q;
    settle_d    = {settle_q[SYNC_STAGES-1:0], 1'b1};

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d   = StActive;
          cpol_d    = CPOL;
          cpha_d    = CPHA;
          tx_sr_d   = hold_full_q ? hold_q : IDLE_TX;
          bit_cnt_d = '0;
          first_d   = 1'b0;
          oe_d      = 1'b1;
          if (hold_full_q) hold_full_d = 1'b0;
        end
      end
      StActive: begin
        if (ss_rise) begin
          // Completed frames leave StActive on their last sample edge, so a
          // deselect here is always an aborted frame.
          state_d     = StIdle;
          oe_d        = 1'b0;
          frame_err_d = 1'b1;
          rx_sr_d     = '0;
        end else if (sample_ev) begin
          rx_sr_d   = rx_shifted;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          first_d   = 1'b1;
          if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
            rx_data_d  = rx_shifted;
            rx_valid_d = 1'b1;
            state_d    = StWaitDesel;
          end
        end else if (change_ev && first_q) begin
          // CPHA=1 leading edge precedes any sample and must not shift.
          tx_sr_d = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
        end
      end
      StWaitDesel: begin
        if (settled && ss_level) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Uses the pre-start buffer state: a load coinciding with frame start
    // is held for the following frame.
    if (TX_LOAD && !hold_full_q) begin
      hold_d      = TX_DATA;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // Start parked so a select already low at release is never joined.
      state_q     <= StWaitDesel;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      oe_q        <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      oe_q        <= oe_d;
      settle_q    <= settle_d;
    end
  end

  // tx_sr is only loaded/shifted while selected, so gating with the enable
  // gives 0 when idle and holds the last bit in StWaitDesel.
  assign MISO      = oe_q & tx_sr_q[0];
  assign MISO_OE   = oe_q;
  assign TX_READY  = ~hold_full_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign BUSY      = (state_q == StActive);
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: drives an SPI master model and checks
// received/transmitted bytes, handshake and status outputs.
module tb_spi_slave_port;

  localparam int H = 6;  // SCLK half period in CLK cycles

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CPOL, CPHA, SCLK, SS_N, MOSI;
  logic       MISO, MISO_OE;
  logic [7:0] TX_DATA;
  logic       TX_LOAD;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID, BUSY, FRAME_ERR;

  int n_assert = 0;
  int n_fail   = 0;
  int rxv_cnt  = 0;
  int ferr_cnt = 0;

  spi_slave_port #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .IDLE_TX    (8'h00)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .SCLK     (SCLK),
    .SS_N     (SS_N),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_OE  (MISO_OE),
    .TX_DATA  (TX_DATA),
    .TX_LOAD  (TX_LOAD),
    .TX_READY (TX_READY),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .BUSY     (BUSY),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RX_VALID) rxv_cnt <= rxv_cnt + 1;
    if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx, input logic [7:0] rx_exp);
    check1({pfx, " MISO"}, MISO, 1'b0);
    check1({pfx, " MISO_OE"}, MISO_OE, 1'b0);
    check1({pfx, " TX_READY"}, TX_READY, 1'b1);
    check8({pfx, " RX_DATA"}, RX_DATA, rx_exp);
    check1({pfx, " RX_VALID"}, RX_VALID, 1'b0);
    check1({pfx, " BUSY"}, BUSY, 1'b0);
    check1({pfx, " FRAME_ERR"}, FRAME_ERR, 1'b0);
  endtask

  task automatic tx_load(input logic [7:0] b);
    TX_DATA = b;
    TX_LOAD = 1'b1;
    wait_clk(1);
    TX_LOAD = 1'b0;
    wait_clk(1);
  endtask

  task automatic spi_begin(input logic cpol, input logic cpha);
    CPOL = cpol;
    CPHA = cpha;
    SCLK = cpol;
    MOSI = 1'b0;
    wait_clk(4);
    SS_N = 1'b0;
    wait_clk(10);
  endtask

  // One bit: master drives MOSI before the slave's sample edge and reads
  // MISO at that same sample edge.
  task automatic spi_bit(input logic cpol, input logic cpha, input logic b, output logic m);
    if (!cpha) begin
      MOSI = b;
      wait_clk(H);
      SCLK = ~cpol;
      m = MISO;
      wait_clk(H);
      SCLK = cpol;
    end else begin
      SCLK = ~cpol;
      MOSI = b;
      wait_clk(H);
      SCLK = cpol;
      m = MISO;
      wait_clk(H);
    end
  endtask

  task automatic spi_end();
    wait_clk(H);
    SS_N = 1'b1;
    wait_clk(10);
  endtask

  task automatic xfer(input string tag, input logic cpol, input logic cpha,
                      input logic [15:0] mosi_word, input int nbits,
                      output logic [7:0] miso_word);
    logic m;
    miso_word = 8'h00;
    spi_begin(cpol, cpha);
    check1({tag, " BUSY at start"}, BUSY, 1'b1);
    check1({tag, " MISO_OE at start"}, MISO_OE, 1'b1);
    check1({tag, " TX_READY at start"}, TX_READY, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(cpol, cpha, mosi_word[i], m);
      if (i < 8) miso_word[i] = m;
    end
    spi_end();
    check1({tag, " MISO_OE after deselect"}, MISO_OE, 1'b0);
    check1({tag, " MISO after deselect"}, MISO, 1'b0);
    check1({tag, " BUSY after deselect"}, BUSY, 1'b0);
  endtask

  initial begin
    logic [7:0] got;
    logic       m;
    int         v0, f0;

    RST_N   = 1'b0;
    CPOL    = 1'b0;
    CPHA    = 1'b0;
    SCLK    = 1'b0;
    SS_N    = 1'b1;
    MOSI    = 1'b0;
    TX_DATA = 8'h00;
    TX_LOAD = 1'b0;
    wait_clk(3);
    check_reset_outputs("reset", 8'h00);
    RST_N = 1'b1;
    wait_clk(6);
    check_reset_outputs("post-reset idle", 8'h00);

    // 1: mode 0, TX 0xA5, master sends 0x3C.
    tx_load(8'hA5);
    check1("t1 TX_READY after load", TX_READY, 1'b0);
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer("t1", 1'b0, 1'b0, 16'h003C, 8, got);
    check8("t1 MISO bits 1,0,1,0,0,1,0,1", got, 8'hA5);
    check8("t1 RX_DATA", RX_DATA, 8'h3C);
    check_int("t1 RX_VALID pulses", rxv_cnt - v0, 1);
    check_int("t1 FRAME_ERR pulses", ferr_cnt - f0, 0);

    // 2: modes 1..3, TX 0x81, master sends 0x7E.
    for (int md = 1; md < 4; md++) begin
      tx_load(8'h81);
      v0 = rxv_cnt;
      xfer("t2", md[1], md[0], 16'h007E, 8, got);
      check8("t2 master receives", got, 8'h81);
      check8("t2 RX_DATA", RX_DATA, 8'h7E);
      check_int("t2 RX_VALID pulses", rxv_cnt - v0, 1);
    end

    // 4: abort after 3 sample edges, then a clean frame.
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer("t4 abort", 1'b0, 1'b0, 16'h00FF, 3, got);
    check_int("t4 FRAME_ERR pulses", ferr_cnt - f0, 1);
    check_int("t4 RX_VALID pulses", rxv_cnt - v0, 0);
    check8("t4 RX_DATA kept", RX_DATA, 8'h7E);
    v0 = rxv_cnt;
    xfer("t4 next", 1'b0, 1'b0, 16'h0055, 8, got);
    check8("t4 next RX_DATA", RX_DATA, 8'h55);
    check8("t4 next master receives idle", got, 8'h00);
    check_int("t4 next RX_VALID pulses", rxv_cnt - v0, 1);

    // 3: no TX_LOAD, master sends 0x00.
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer("t3", 1'b0, 1'b0, 16'h0000, 8, got);
    check8("t3 master receives IDLE_TX", got, 8'h00);
    check8("t3 RX_DATA", RX_DATA, 8'h00);
    check_int("t3 RX_VALID pulses", rxv_cnt - v0, 1);
    check_int("t3 FRAME_ERR pulses", ferr_cnt - f0, 0);

    // 5: 10 SCLK cycles in one select; only the first 8 count.
    tx_load(8'h96);
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer("t5", 1'b0, 1'b0, 16'h02C3, 10, got);
    check8("t5 RX_DATA first 8 bits", RX_DATA, 8'hC3);
    check8("t5 master receives", got, 8'h96);
    check_int("t5 RX_VALID pulses", rxv_cnt - v0, 1);
    check_int("t5 FRAME_ERR pulses", ferr_cnt - f0, 0);

    // 6: reset during bit 4, released with SS_N still low.
    tx_load(8'h33);
    v0 = rxv_cnt;
    spi_begin(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, 1'b1, m);
    MOSI = 1'b1;
    wait_clk(H);
    SCLK = 1'b1;
    wait_clk(2);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("t6 in reset", 8'h00);
    wait_clk(2);
    RST_N = 1'b1;
    wait_clk(H);
    SCLK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b0, 1'b0, 1'b0, m);
      check1("t6 MISO_OE stays low", MISO_OE, 1'b0);
      check1("t6 BUSY stays low", BUSY, 1'b0);
    end
    spi_end();
    check1("t6 MISO_OE after deselect", MISO_OE, 1'b0);
    check_int("t6 RX_VALID pulses", rxv_cnt - v0, 0);
    check8("t6 RX_DATA reset value", RX_DATA, 8'h00);
    tx_load(8'h0F);
    v0 = rxv_cnt;
    xfer("t6 next", 1'b0, 1'b0, 16'h00F0, 8, got);
    check8("t6 next RX_DATA", RX_DATA, 8'hF0);
    check8("t6 next master receives", got, 8'h0F);
    check_int("t6 next RX_VALID pulses", rxv_cnt - v0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- Synthesizable SPI slave endpoint: the downstream consumer of the master's SCLK/MOSI/slave-select outputs and the producer of its MISO.
- Oversamples the SPI pins on a local system clock and supports all four CPOL/CPHA modes.
- Performs one full-duplex, LSB-first, DATA_WIDTH-bit exchange per select window.
- Hands received bytes to local logic with a valid pulse and accepts a transmit byte through a load/ready handshake.

Parameters:
DATA_WIDTH, 8, frame length in bits and width of TX/RX data.
SYNC_STAGES, 2, flip-flops in each pin synchronizer (minimum 2).
IDLE_TX, 0, value shifted out when no TX byte was loaded before frame start.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
CPOL  input  1  SPI clock idle level; captured at frame start.
CPHA  input  1  SPI clock phase; captured at frame start.
SCLK  input  1  SPI clock from master, asynchronous to CLK.
SS_N  input  1  active-low slave select from master, asynchronous.
MOSI  input  1  serial data from master.
MISO  output  1  serial data to master.
MISO_OE  output  1  high while selected; tri-state enable at pad.
TX_DATA  input  DATA_WIDTH  byte to transmit next frame.
TX_LOAD  input  1  one-cycle load strobe; accepted only when TX_READY=1.
TX_READY  output  1  TX holding buffer empty.
RX_DATA  output  DATA_WIDTH  last completely received frame; held until next completion.
RX_VALID  output  1  one-cycle pulse when RX_DATA updates.
BUSY  output  1  frame in progress (ACTIVE state).
FRAME_ERR  output  1  one-cycle pulse when SS_N deasserts mid-frame.

Behaviour:
- Reset values: MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, BUSY=0, FRAME_ERR=0, bit count 0, holding buffer empty.
- Synchronization: SCLK, SS_N and MOSI each pass through SYNC_STAGES flops. Edge detect compares the last synchronized stage with one extra flop.
- Latency: a pin edge is acted on SYNC_STAGES+1 CLK cycles after it occurs.
- Timing requirement: SCLK high and low times must each be at least SYNC_STAGES+2 CLK periods.
- Edge roles: sample edge is rising when CPOL^CPHA=0, falling otherwise; the opposite edge is the change edge.
- FSM states:
  - IDLE: waits for SS_N low.
  - ACTIVE: frame in progress.
  - WAIT_DESEL: frame complete or joined late; waits for SS_N high.
- IDLE->ACTIVE on synced SS_N falling edge. Same cycle:
  - latch CPOL/CPHA;
  - load tx_sr from the holding buffer if full (buffer then empties, TX_READY=1), else from IDLE_TX;
  - clear bit count and the first-sample flag;
  - set MISO_OE=1.
- ACTIVE, MISO: MISO=tx_sr[0] continuously, so the first bit is valid before the first edge in both phases.
- ACTIVE, sample edge: rx_sr <= {MOSI_sync, rx_sr[DATA_WIDTH-1:1]}; increment bit count; set the first-sample flag.
- ACTIVE, change edge: tx_sr shifts right one bit only if the first-sample flag is set. Change edges before the first sample (CPHA=1 leading edge) are ignored.
- Frame completion: on the sample edge that makes bit count equal DATA_WIDTH, RX_DATA <= the completed word and RX_VALID pulses the next cycle. Go to WAIT_DESEL.
- WAIT_DESEL: all SCLK edges ignored; MISO holds its last bit; SS_N rising -> IDLE with MISO_OE=0 and MISO=0.
- Abort: SS_N rising while ACTIVE with bit count < DATA_WIDTH -> FRAME_ERR pulse, rx_sr discarded, RX_DATA unchanged, IDLE. A TX byte already moved into tx_sr is consumed, not restored.
- TX handshake:
  - TX_LOAD with TX_READY=1 writes the holding buffer and drops TX_READY next cycle; accepted in any state.
  - TX_LOAD with TX_READY=0 is ignored.
  - TX_LOAD in the same cycle as frame start: the old buffer content goes to tx_sr and the new byte is held for the following frame.
- Reset release with synced SS_N low: start in WAIT_DESEL, so the slave never joins a frame mid-way. Synchronizers reset to 1 (deselected, matching idle SS_N).
- Reset asserted mid-frame: all outputs go to their reset values immediately.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, ACTIVE, WAIT_DESEL};
  - mode constant helper function sample_rising(cpol, cpha);
  - default DATA_WIDTH constant.
- One sub-module, spi_sync_edge: parameterized synchronizer plus rise/fall pulse detector with a parameterized reset value. Instantiated for SCLK, SS_N and MOSI (MOSI uses only the level output).

Test Plan:
1. Mode 0: TX_LOAD 0xA5, master sends 0x3C LSB-first. Required: MISO bits 1,0,1,0,0,1,0,1; RX_DATA=0x3C with a single RX_VALID pulse; TX_READY=1 after frame start.
2. Modes 1, 2 and 3 in turn: TX 0x81, master sends 0x7E. Required: RX_DATA=0x7E and master receives 0x81 in each mode; no shift on the CPHA=1 leading edge.
3. No TX_LOAD before frame: master sends 0x00. Required: MISO shifts IDLE_TX=0x00; RX_VALID pulses; FRAME_ERR=0.
4. Abort after 3 sample edges (SS_N rises). Required: FRAME_ERR pulse, no RX_VALID, RX_DATA keeps its previous value 0x7E, state IDLE. Next full frame 0x55 is received correctly.
5. 10 SCLK cycles within one select. Required: RX_DATA equals the first 8 bits, exactly one RX_VALID, last 2 cycles ignored.
6. Deassert RST_N during bit 4, release with SS_N still low. Required: all outputs at reset values, no RX_VALID for that frame, MISO_OE stays 0 until SS_N rises and falls again.
